spi_fb_fifo_ctrl: RTL and testbench

Byte-FIFO controller that sequences one simple dual-port, single-clock byte RAM (1-cycle registered read, depth 2^ADDRL) as a ring buffer. It sits between the SPI byte receiver (push side) and the display scan-out/consumer (pop side), owns all RAM address, enable and write-enable generation, and hides the RAM read latency behind a 2-entry output buffer so streaming runs at one byte per cycle.

---
 rtl/spiglass_pkg.sv | 11 +
 rtl/spi_fb_out_buf.sv | 42 ++++
 rtl/spi_fb_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_spi_fb_fifo_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spiglass_pkg.sv
// Shared constants and helpers for the spiglass SPI frame-buffer datapath.
package spiglass_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned OUT_BUF_DEPTH = 2;

  function automatic int unsigned depth_of(input int unsigned addrl);
    return 32'd1 << addrl;
  endfunction

endpackage

// File: rtl/spi_fb_out_buf.sv
// Two-entry output buffer absorbing the RAM read latency; head is the FIFO output byte.
module spi_fb_out_buf
  import spiglass_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              capture,
  input  logic [BYTE_W-1:0] cap_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic [1:0]        cnt
);

  logic [BYTE_W-1:0] mem [OUT_BUF_DEPTH];
  logic              hd;
  logic [1:0]        cnt_q;
  logic              tail;

  // With two slots the tail is hd^cnt[0]; at cnt==2 that lands on the slot being popped.
  always_comb begin
    tail = hd ^ cnt_q[0];
    head = mem[hd];
    cnt  = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '{default: '0};
      hd    <= 1'b0;
      cnt_q <= '0;
    end else if (clear) begin
      hd    <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (capture) mem[tail] <= cap_data;
      if (pop)     hd <= ~hd;
      cnt_q <= cnt_q + {1'b0, capture} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/spi_fb_fifo_ctrl.sv
// Ring-buffer controller over a 1-cycle-latency byte RAM with a 2-entry output buffer.
module spi_fb_fifo_ctrl
  import spiglass_pkg::*;
#(
  parameter int unsigned ADDRL = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [ADDRL:0]    level,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDRL-1:0]  ram_addra,
  output logic [BYTE_W-1:0] ram_dia,
  output logic              ram_enb,
  output logic [ADDRL-1:0]  ram_addrb,
  input  logic [BYTE_W-1:0] ram_dob
);

  localparam logic [ADDRL:0]   DEPTH   = (ADDRL+1)'(depth_of(ADDRL));
  localparam logic [ADDRL-1:0] PTR_ONE = ADDRL'(1);
  localparam logic [ADDRL:0]   LVL_ONE = (ADDRL+1)'(1);

  logic             run;
  logic [ADDRL-1:0] wptr, rptr;
  logic [ADDRL:0]   ram_lvl;
  logic [ADDRL:0]   level_q;
  logic             rd_pend;
  logic [1:0]       buf_cnt;
  logic [2:0]       occ;
  logic             push, pop, issue;
  logic [BYTE_W-1:0] head;

  // run holds in_ready low until the first edge after reset release.
  always_comb begin
    in_ready  = run && !flush && (ram_lvl != DEPTH);
    out_valid = !flush && (buf_cnt != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    occ       = {1'b0, buf_cnt} + {2'b0, rd_pend};
    issue     = !flush && (ram_lvl != '0) && (occ <= (3'd1 + {2'b0, pop}));
    ram_ena   = push;
    ram_wea   = push;
    ram_addra = wptr;
    ram_dia   = push ? in_data : '0;
    ram_enb   = issue;
    ram_addrb = rptr;
    out_data  = head;
    level     = level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      ram_lvl <= '0;
      rd_pend <= 1'b0;
      level_q <= '0;
    end else if (flush) begin
      run     <= 1'b1;
      wptr    <= '0;
      rptr    <= '0;
      ram_lvl <= '0;
      rd_pend <= 1'b0;
      level_q <= '0;
    end else begin
      run     <= 1'b1;
      rd_pend <= issue;
      if (push)  wptr <= wptr + PTR_ONE;
      if (issue) rptr <= rptr + PTR_ONE;
      case ({push, issue})
        2'b10:   ram_lvl <= ram_lvl + LVL_ONE;
        2'b01:   ram_lvl <= ram_lvl - LVL_ONE;
        default: ram_lvl <= ram_lvl;
      endcase
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  spi_fb_out_buf u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .capture  (rd_pend),
    .cap_data (ram_dob),
    .pop      (pop),
    .head     (head),
    .cnt      (buf_cnt)
  );

endmodule

// File: tb/tb_spi_fb_fifo_ctrl.sv
// Randomized bench for spi_fb_fifo_ctrl against a queue-based FIFO reference model.
module tb_spi_fb_fifo_ctrl;

  localparam int unsigned ADDRL = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [ADDRL:0]   level;
  logic             ram_ena, ram_wea, ram_enb;
  logic [ADDRL-1:0] ram_addra, ram_addrb;
  logic [7:0]       ram_dia, ram_dob;

  logic [7:0] ram [16];
  logic [7:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;
  int n_pop = 0;
  int cyc = 0;
  int first_pop = -1;
  int last_pop = -1;

  spi_fb_fifo_ctrl #(.ADDRL(ADDRL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_ena && ram_wea) ram[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= ram[ram_addrb];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample handshakes mid-low-phase, update the model, then advance one cycle.
  task automatic tick();
    logic p, o;
    #2;
    p = in_valid && in_ready;
    o = out_valid && out_ready;
    if (o) begin
      if (q.size() == 0) chk("pop_on_empty", 32'(out_valid), 32'd0);
      else               chk("pop_data", 32'(out_data), 32'(q.pop_front()));
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (p) begin
      q.push_back(in_data);
      n_push++;
    end
    if (flush) q.delete();
    @(negedge clk);
    cyc++;
    if (rst_n) chk("level", 32'(level), 32'(q.size()));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_level"},     32'(level),     32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_ram_ena"},   32'(ram_ena),   32'd0);
    chk({tag, "_ram_wea"},   32'(ram_wea),   32'd0);
    chk({tag, "_ram_enb"},   32'(ram_enb),   32'd0);
    chk({tag, "_ram_addra"}, 32'(ram_addra), 32'd0);
    chk({tag, "_ram_addrb"}, 32'(ram_addrb), 32'd0);
    chk({tag, "_ram_dia"},   32'(ram_dia),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, acc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1 chk("ready_after_reset", 32'(in_ready), 32'd1);

    // single byte latency
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1 chk("first_ram_ena", 32'(ram_ena), 32'd1);
    tick();
    in_valid = 1'b0;
    #1 chk("first_ram_enb", 32'(ram_enb), 32'd1);
    tick();
    #1 chk("first_not_yet_valid", 32'(out_valid), 32'd0);
    tick();
    #1 chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_data", 32'(out_data), 32'hA5);
    tick();
    chk("first_level_after_pop", 32'(level), 32'd0);

    // back-to-back streaming
    first_pop = -1; base = cyc; acc = n_pop;
    for (int unsigned i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1 chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 8; i++) tick();
    chk("stream_pops", 32'(n_pop - acc), 32'd32);
    chk("stream_latency", 32'(first_pop - base), 32'd3);
    chk("stream_contiguous", 32'(last_pop - first_pop), 32'd31);

    // fill to capacity with consumer stalled
    out_ready = 1'b0; acc = n_push;
    for (int unsigned i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #1 chk("full_accepted", 32'(n_push - acc), 32'd18);
    chk("full_level", 32'(level), 32'd18);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    #1 chk("refill_in_ready", 32'(in_ready), 32'd1);
    chk("refill_level", 32'(level), 32'd17);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 24; i++) tick();
    chk("full_drained", 32'(q.size()), 32'd0);

    // random stalls across wrap
    acc = n_push; base = cyc;
    while ((n_push - acc) < 50 && (cyc - base) < 1000) begin
      in_valid = ($urandom_range(0, 3) != 0); in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    chk("rand_pushed", 32'(n_push - acc), 32'd50);
    in_valid = 1'b0; out_ready = 1'b1;
    base = cyc;
    while (q.size() != 0 && (cyc - base) < 100) tick();
    chk("rand_drained", 32'(q.size()), 32'd0);

    // flush with a read in flight
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_ram_ena", 32'(ram_ena), 32'd0);
    chk("flush_ram_enb", 32'(ram_enb), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("post_flush_out_valid", 32'(out_valid), 32'd0);
    chk("post_flush_level", 32'(level), 32'd0);
    acc = n_pop;
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 6; i++) tick();
    chk("post_flush_pops", 32'(n_pop - acc), 32'd1);

    // asynchronous reset mid-stream
    for (int unsigned i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1 chk("resume_in_ready", 32'(in_ready), 32'd1);
    chk("resume_out_valid", 32'(out_valid), 32'd0);
    acc = n_pop;
    for (int unsigned i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 8; i++) tick();
    chk("resume_pops", 32'(n_pop - acc), 32'd3);
    chk("resume_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
